// File: rtl/demux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// demux_scan_sequencer
//
// Upstream driver for the 1-to-8 demultiplexer. Accepts one byte per
// valid/ready transfer and steps the demux select `s` through all eight
// channels. Each channel is held for DWELL clocks, and `i` carries the
// matching bit of the captured byte.
//
// Build option:
//   SCAN_MSB_FIRST_EN  defined   -> channel order 7,6,...,0
//                      undefined -> channel order 0,1,...,7
//
// Parameters:
//   DWELL       clocks per channel, 1..16 (held in a 4-bit counter as DWELL-1)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    upstream byte valid
//   in_ready    byte can be accepted (from internal state only)
//   in_data     byte to distribute; bit k goes to channel k
//   s           demux select (registered)
//   i           demux data (registered)
//   busy        frame in progress (registered)
//   frame_done  one-cycle pulse after a frame's last channel (registered)
// ---------------------------------------------------------------------------
module demux_scan_sequencer #(
  parameter int DWELL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [2:0] s,
  output logic       i,
  output logic       busy,
  output logic       frame_done
);

  // state | meaning
  // IDLE  | no frame in progress, s/i parked at 0
  // SCAN  | a captured byte is being distributed channel by channel
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [3:0] DWELL_M1 = 4'(DWELL - 1);

`ifdef SCAN_MSB_FIRST_EN
  localparam logic [2:0] CH_FIRST = 3'd7;
  localparam logic [2:0] CH_LAST  = 3'd0;
`else
  localparam logic [2:0] CH_FIRST = 3'd0;
  localparam logic [2:0] CH_LAST  = 3'd7;
`endif

  state_t     state, state_nxt;
  logic [7:0] hold, hold_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] s_nxt;
  logic       i_nxt;
  logic       busy_nxt;
  logic       frame_done_nxt;

  logic       last_dwell;
  logic       xfer;
  logic [2:0] ch_next;

`ifdef SCAN_MSB_FIRST_EN
  assign ch_next = s - 3'd1;
`else
  assign ch_next = s + 3'd1;
`endif

  // The final dwell cycle of the last channel doubles as the accept window,
  // so a waiting byte starts on the very next cycle with no gap.
  assign last_dwell = (cnt == 4'd0) && (s == CH_LAST);
  assign in_ready   = (state == IDLE) || last_dwell;
  assign xfer       = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold       <= 8'h00;
      cnt        <= 4'd0;
      s          <= 3'd0;
      i          <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold       <= hold_nxt;
      cnt        <= cnt_nxt;
      s          <= s_nxt;
      i          <= i_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hold_nxt       = hold;
    cnt_nxt        = cnt;
    s_nxt          = s;
    i_nxt          = i;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt = SCAN;
          hold_nxt  = in_data;
          cnt_nxt   = DWELL_M1;
          s_nxt     = CH_FIRST;
          i_nxt     = in_data[CH_FIRST];
          busy_nxt  = 1'b1;
        end
      end

      SCAN: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else if (s != CH_LAST) begin
          s_nxt   = ch_next;
          i_nxt   = hold[ch_next];
          cnt_nxt = DWELL_M1;
        end else begin
          frame_done_nxt = 1'b1;
          if (xfer) begin
            hold_nxt = in_data;
            cnt_nxt  = DWELL_M1;
            s_nxt    = CH_FIRST;
            i_nxt    = in_data[CH_FIRST];
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
            s_nxt     = 3'd0;
            i_nxt     = 1'b0;
            busy_nxt  = 1'b0;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
        s_nxt     = 3'd0;
        i_nxt     = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_demux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_demux_scan_sequencer
//
// Two sequencers (DWELL=1 and DWELL=3) share the same input stream. Every
// accepted byte pushes its expected per-cycle {s,i} sequence onto a queue
// for that instance. Each cycle, the head of the queue is popped and compared
// with the instance's outputs. Honours SCAN_MSB_FIRST_EN for channel order.
// ---------------------------------------------------------------------------
module tb_demux_scan_sequencer;

  localparam int DW_A = 1;
  localparam int DW_B = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       rdy_a, i_a, busy_a, fd_a;
  logic [2:0] s_a;
  logic       rdy_b, i_b, busy_b, fd_b;
  logic [2:0] s_b;

  always #5 clk = ~clk;

  demux_scan_sequencer #(.DWELL(DW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(in_data), .s(s_a), .i(i_a), .busy(busy_a), .frame_done(fd_a)
  );

  demux_scan_sequencer #(.DWELL(DW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
    .in_data(in_data), .s(s_b), .i(i_b), .busy(busy_b), .frame_done(fd_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] q_a[$];
  logic [3:0] q_b[$];
  logic       fd_exp_a = 1'b0;
  logic       fd_exp_b = 1'b0;
  logic       x_a, x_b;

  function automatic logic [2:0] order_ch(input int k);
`ifdef SCAN_MSB_FIRST_EN
    return 3'(7 - k);
`else
    return 3'(k);
`endif
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic lane_check(input string tag, input int qn, input logic [3:0] hd,
                            input logic fde, input logic [2:0] s_o, input logic i_o,
                            input logic b_o, input logic r_o, input logic f_o);
    if (qn > 0) begin
      check_val({tag, ".s"},     32'(s_o), 32'(hd[3:1]));
      check_val({tag, ".i"},     32'(i_o), 32'(hd[0]));
      check_val({tag, ".busy"},  32'(b_o), 32'd1);
      check_val({tag, ".ready"}, 32'(r_o), (qn == 1) ? 32'd1 : 32'd0);
    end else begin
      check_val({tag, ".s_idle"},     32'(s_o), 32'd0);
      check_val({tag, ".i_idle"},     32'(i_o), 32'd0);
      check_val({tag, ".busy_idle"},  32'(b_o), 32'd0);
      check_val({tag, ".ready_idle"}, 32'(r_o), 32'd1);
    end
    check_val({tag, ".frame_done"}, 32'(f_o), 32'(fde));
  endtask

  // Reference model: a byte is accepted when the queue is empty or on its last entry.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
      fd_exp_a = 1'b0;
      fd_exp_b = 1'b0;
    end else begin
      x_a = in_valid && (q_a.size() <= 1);
      x_b = in_valid && (q_b.size() <= 1);
      fd_exp_a = (q_a.size() == 1);
      fd_exp_b = (q_b.size() == 1);
      if (q_a.size() > 0) void'(q_a.pop_front());
      if (q_b.size() > 0) void'(q_b.pop_front());
      for (int k = 0; k < 8; k++) begin
        for (int d = 0; d < DW_A; d++)
          if (x_a) q_a.push_back({order_ch(k), in_data[order_ch(k)]});
        for (int d = 0; d < DW_B; d++)
          if (x_b) q_b.push_back({order_ch(k), in_data[order_ch(k)]});
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] hd_a, hd_b;
    hd_a = (q_a.size() > 0) ? q_a[0] : 4'h0;
    hd_b = (q_b.size() > 0) ? q_b[0] : 4'h0;
    lane_check("a", q_a.size(), hd_a, fd_exp_a, s_a, i_a, busy_a, rdy_a, fd_a);
    lane_check("b", q_b.size(), hd_b, fd_exp_b, s_b, i_b, busy_b, rdy_b, fd_b);
  end

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_wait(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(negedge clk);
    end
    check_val("idle_wait.pending", 32'(q_a.size() + q_b.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single byte
    send_byte(8'hA5);
    idle_wait(40);

    // back-to-back frames with in_valid held
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    in_data  = 8'h00;
    repeat (26) @(negedge clk);
    in_valid = 1'b0;
    idle_wait(60);

    // dwell-focused single bit
    send_byte(8'h01);
    idle_wait(40);

    // backpressure: data changes before the ready window
    send_byte(8'h55);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    in_data  = 8'h5A;
    repeat (24) @(negedge clk);
    in_valid = 1'b0;
    idle_wait(60);

    // reset mid-scan: dut_a at s=4 (default order)
    send_byte(8'hFF);
    repeat (4) @(negedge clk);
    check_val("pre_rst.busy_a", 32'(busy_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst.s_a",    32'(s_a),    32'd0);
    check_val("rst.i_a",    32'(i_a),    32'd0);
    check_val("rst.busy_a", 32'(busy_a), 32'd0);
    check_val("rst.fd_a",   32'(fd_a),   32'd0);
    check_val("rst.s_b",    32'(s_b),    32'd0);
    check_val("rst.busy_b", 32'(busy_b), 32'd0);
    check_val("rst.ready_a", 32'(rdy_a), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'hC3;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h80);
    idle_wait(40);

    // random traffic
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    idle_wait(60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_scan_sequencer.md
# demux_scan_sequencer

Upstream driver for the 1-to-8 demultiplexer (`demux8to1B`). It accepts one 8-bit byte per valid/ready transfer and drives the demux select `s` and data `i` so that each bit of the byte is steered to its own output channel in turn. Each channel is held for a fixed number of clock cycles. It converts a parallel byte stream into the time-multiplexed select/data pair that the combinational demux consumes.

## Interface
- `DWELL`, default 1: clock cycles each channel is held; legal range 1..16; stored in a 4-bit counter as DWELL-1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: upstream byte valid.
- `in_ready` output 1: sequencer can accept a byte; combinational from state and counters.
- `in_data` input 8: byte to distribute; bit k goes to channel k.
- `s` output 3: demux select, registered.
- `i` output 1: demux data, registered.
- `busy` output 1: high while a frame is being scanned, registered.
- `frame_done` output 1: one-cycle pulse after a frame's last channel, registered.

## Operation
- **FSM states:**
  - IDLE: no frame in progress.
  - SCAN: a frame is being distributed.
- **Transfer:** occurs on a rising edge when `in_valid && in_ready`. `in_data` is captured into an 8-bit holding register.
- **`in_ready`:**
  - 1 in IDLE.
  - 1 in SCAN only during the final dwell cycle of the last channel; this allows back-to-back frames.
  - 0 otherwise.
- **IDLE → SCAN:** on transfer.
  - `s` <= first channel; `i` <= `in_data[first]`; dwell counter <= DWELL-1; `busy` <= 1.
- **SCAN, dwell counter > 0:** decrement the counter; `s` and `i` hold.
- **SCAN, dwell counter = 0, not the last channel:**
  - `s` <= next channel; `i` <= `hold[next]`; reload the counter.
- **SCAN, dwell counter = 0, last channel:**
  - `frame_done` <= 1 for one cycle.
  - If a transfer occurs on the same edge, stay in SCAN, load the new byte, and start at the first channel. There is no gap cycle.
  - Otherwise go to IDLE with `s` <= 3'd0, `i` <= 0, `busy` <= 0.
- **Idle outputs:** in IDLE, `s` = 0 and `i` = 0, so every demux output `y` reads 0.
- **`in_valid` during SCAN:** ignored outside the in_ready window; upstream must hold the byte until it is accepted.
- **`in_data` changes mid-frame:** have no effect; only the holding register is used.
- **Reset (any time, including mid-scan):**
  - Immediately forces IDLE, `s`=3'd0, `i`=0, `busy`=0, `frame_done`=0, holding register=0, dwell counter=0.
  - The partial frame is discarded and `frame_done` is not pulsed.
  - `in_ready` reads 1 while in reset; transfers are not captured while `rst_n`=0.

## Timing
- **Latency:** a byte accepted at edge N has its first channel on `s`/`i` in the cycle after edge N.
- **Frame length:** each channel is driven for exactly DWELL cycles; a frame occupies exactly 8×DWELL cycles.
- **`frame_done`:** high in the cycle immediately after the last channel's final dwell cycle. That cycle is either the first cycle of the next frame or the first IDLE cycle.
- **Throughput:** one byte per 8×DWELL cycles with continuous `in_valid`.
- **Output paths:** `s`, `i`, `busy` and `frame_done` are flop outputs with no combinational path from inputs. `in_ready` is combinational from internal state only and does not depend on `in_valid`.

## Configuration
- **`SCAN_MSB_FIRST_EN`:**
  - Defined: channel order is 7,6,…,0. The first channel is 7 and the last is 0.
  - Undefined: channel order is 0,1,…,7. The first channel is 0 and the last is 7.
  - Reset and IDLE values of `s` are 3'd0 in both builds.

## Test plan
- **Single byte, default order:** DWELL=1, 8'hA5 accepted at edge N.
  - Required: `s`=0..7 on cycles N+1..N+8, `i`=1,0,1,0,0,1,0,1.
  - Required: `frame_done` high only on cycle N+9; `busy` high cycles N+1..N+8; `s`=0, `i`=0 after.
- **Back-to-back frames:** DWELL=1, `in_valid` held with 8'hFF then 8'h00.
  - Required: `in_ready`=1 only on the `s`=7 cycle; 16 consecutive scan cycles with no gap.
  - Required: `i`=1 for the first 8 cycles and 0 for the next 8; `frame_done` coincides with `s`=0 of frame 2.
- **Dwell:** DWELL=3, 8'h01.
  - Required: `s`=0 held 3 cycles with `i`=1, then channels 1..7 each held 3 cycles with `i`=0; 24 scan cycles in total.
- **Reset mid-scan:** DWELL=2, 8'hFF; assert `rst_n`=0 while `s`=4.
  - Required: `s`=0, `i`=0, `busy`=0 immediately and asynchronously; no `frame_done`.
  - Required: after release, a new byte 8'h80 scans normally.
- **Backpressure:** during SCAN, present 8'h3C with `in_valid`=1 and change `in_data` before the ready window.
  - Required: only the value present on the `in_ready` cycle is captured; the current frame's `i` sequence is unaffected.
- **`SCAN_MSB_FIRST_EN` defined:** DWELL=1, 8'hA5.
  - Required: `s`=7,6,…,0 with `i`=1,0,1,0,0,1,0,1; `in_ready` window and `frame_done` aligned to `s`=0.
